// File: rtl/frac_baud_generator.sv
// Fractional baud-rate generator.
// Produces single-cycle clock enables (never derived clocks) from a
// runtime-loadable integer-plus-fraction divisor. The sample period is
// DivisorInteger clocks, lengthened by one clock whenever the fractional
// accumulator carries. Over time the average period is
// DivisorInteger + DivisorFraction / 2^FRAC_BITS clocks.
//
// Ports:
//   Clock           system clock, rising edge
//   Reset           synchronous, active-high
//   Enable          count enable; when low all state holds and ticks are low
//   DivisorInteger  integer part of a new divisor
//   DivisorFraction fractional part of a new divisor (units of 1/2^FRAC_BITS)
//   LoadDivisor     strobe: capture the divisor inputs and restart timing
//   Resync          strobe: restart the bit phase (e.g. on a start-bit edge)
//   SampleTick      one-cycle oversampling enable
//   BitTick         one-cycle enable once per bit period
//   MidBitTick      one-cycle enable at the middle of each bit
//   SampleIndex     sample-tick count within the current bit
//   DivisorClamped  sticky: the last load asked for an integer part below 2
module frac_baud_generator #(
  parameter int unsigned DIV_WIDTH     = 16,
  parameter int unsigned FRAC_BITS     = 4,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned RESET_DIVISOR = 326,
  parameter int unsigned IDX_WIDTH     = $clog2(OVERSAMPLE)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [DIV_WIDTH-1:0] DivisorInteger,
  input  logic [FRAC_BITS-1:0] DivisorFraction,
  input  logic                 LoadDivisor,
  input  logic                 Resync,
  output logic                 SampleTick,
  output logic                 BitTick,
  output logic                 MidBitTick,
  output logic [IDX_WIDTH-1:0] SampleIndex,
  output logic                 DivisorClamped
);

  localparam logic [IDX_WIDTH-1:0] LastIndex = IDX_WIDTH'(OVERSAMPLE - 1);
  localparam logic [IDX_WIDTH-1:0] MidIndex  = IDX_WIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] MinDiv    = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0] actInt;
  logic [FRAC_BITS-1:0] actFrac;
  logic [FRAC_BITS-1:0] acc;
  logic                 extend;
  logic [DIV_WIDTH:0]   counter;
  logic [DIV_WIDTH:0]   termCount;
  logic [FRAC_BITS:0]   accSum;
  logic                 terminal;

  // Counter is one bit wider than actInt so the extended terminal value
  // (actInt when extend is set) always fits without wrapping.
  always_comb begin
    termCount = {1'b0, actInt} - (DIV_WIDTH + 1)'(1)
              + {{DIV_WIDTH{1'b0}}, extend};
    terminal  = (counter == termCount);
    accSum    = {1'b0, acc} + {1'b0, actFrac};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      actInt         <= DIV_WIDTH'(RESET_DIVISOR);
      actFrac        <= '0;
      counter        <= '0;
      acc            <= '0;
      extend         <= 1'b0;
      SampleIndex    <= '0;
      SampleTick     <= 1'b0;
      BitTick        <= 1'b0;
      MidBitTick     <= 1'b0;
      DivisorClamped <= 1'b0;
    end else if (LoadDivisor) begin
      // A simultaneous Resync is absorbed: the load clears the same state.
      actInt         <= (DivisorInteger < MinDiv) ? MinDiv : DivisorInteger;
      actFrac        <= DivisorFraction;
      DivisorClamped <= (DivisorInteger < MinDiv);
      counter        <= '0;
      acc            <= '0;
      extend         <= 1'b0;
      SampleIndex    <= '0;
      SampleTick     <= 1'b0;
      BitTick        <= 1'b0;
      MidBitTick     <= 1'b0;
    end else if (Resync) begin
      counter     <= '0;
      acc         <= '0;
      extend      <= 1'b0;
      SampleIndex <= '0;
      SampleTick  <= 1'b0;
      BitTick     <= 1'b0;
      MidBitTick  <= 1'b0;
    end else if (Enable) begin
      if (terminal) begin
        counter     <= '0;
        acc         <= accSum[FRAC_BITS-1:0];
        extend      <= accSum[FRAC_BITS];
        SampleIndex <= SampleIndex + 1'b1;
        SampleTick  <= 1'b1;
        BitTick     <= (SampleIndex == LastIndex);
        MidBitTick  <= (SampleIndex == MidIndex);
      end else begin
        counter    <= counter + 1'b1;
        SampleTick <= 1'b0;
        BitTick    <= 1'b0;
        MidBitTick <= 1'b0;
      end
    end else begin
      SampleTick <= 1'b0;
      BitTick    <= 1'b0;
      MidBitTick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frac_baud_generator.sv
module tb_frac_baud_generator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [15:0] DivisorInteger = '0;
  logic [3:0]  DivisorFraction = '0;
  logic        LoadDivisor = 1'b0;
  logic        Resync = 1'b0;
  logic        SampleTick;
  logic        BitTick;
  logic        MidBitTick;
  logic [3:0]  SampleIndex;
  logic        DivisorClamped;

  int vectorCount = 0;
  int missCount = 0;

  frac_baud_generator #(
    .DIV_WIDTH(16),
    .FRAC_BITS(4),
    .OVERSAMPLE(16),
    .RESET_DIVISOR(326)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Enable(Enable),
    .DivisorInteger(DivisorInteger),
    .DivisorFraction(DivisorFraction),
    .LoadDivisor(LoadDivisor),
    .Resync(Resync),
    .SampleTick(SampleTick),
    .BitTick(BitTick),
    .MidBitTick(MidBitTick),
    .SampleIndex(SampleIndex),
    .DivisorClamped(DivisorClamped)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic checkValue(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  // Returns clocks elapsed until SampleTick is seen, or -1 on timeout.
  task automatic waitTick(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge Clock);
      cycles++;
    end while (!SampleTick && cycles < budget);
    if (!SampleTick) begin
      checkValue("tick_timeout", 0, 1);
      cycles = -1;
    end
  endtask

  task automatic doReset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic doLoad(input int divInt, input int divFrac);
    @(negedge Clock);
    DivisorInteger  = 16'(divInt);
    DivisorFraction = 4'(divFrac);
    LoadDivisor     = 1'b1;
    @(negedge Clock);
    LoadDivisor = 1'b0;
  endtask

  initial begin
    int period;
    int total;
    int bitTime [2];
    int bitSeen;
    int midTime;
    int anyTick;

    // Reset state
    Enable = 1'b1;
    doReset();
    checkValue("rst_sample", SampleTick, 0);
    checkValue("rst_bit", BitTick, 0);
    checkValue("rst_mid", MidBitTick, 0);
    checkValue("rst_index", SampleIndex, 0);
    checkValue("rst_clamp", DivisorClamped, 0);

    // Integer divisor 4: 4-clock samples, 64-clock bits, mid 32 after bit
    doLoad(4, 0);
    checkValue("load_tick0", SampleTick, 0);
    total = 0;
    bitSeen = 0;
    midTime = 0;
    for (int i = 0; i < 32; i++) begin
      waitTick(20, period);
      total += period;
      checkValue($sformatf("d4_period%0d", i), period, 4);
      checkValue($sformatf("d4_index%0d", i), SampleIndex, (i + 1) % 16);
      checkValue($sformatf("d4_bit%0d", i), BitTick, ((i + 1) % 16 == 0) ? 1 : 0);
      checkValue($sformatf("d4_mid%0d", i), MidBitTick, ((i + 1) % 16 == 8) ? 1 : 0);
      if (BitTick && bitSeen < 2) begin
        bitTime[bitSeen] = total;
        bitSeen++;
      end
      if (MidBitTick && bitSeen == 1) midTime = total;
    end
    checkValue("d4_bitcount", bitSeen, 2);
    if (bitSeen == 2) checkValue("d4_bitperiod", bitTime[1] - bitTime[0], 64);
    if (bitSeen >= 1) checkValue("d4_bit_to_mid", midTime - bitTime[0], 32);

    // Divisor 4.5: periods 4,4,5,4,5,... and 144 clocks per 32 steady ticks
    doLoad(4, 8);
    total = 0;
    for (int i = 0; i < 34; i++) begin
      waitTick(20, period);
      if (i >= 2) total += period;
      checkValue($sformatf("d45_period%0d", i), period,
                 (i >= 2 && i % 2 == 0) ? 5 : 4);
    end
    checkValue("d45_total32", total, 144);

    // Reset restores 326/0: first tick after 326 clocks, first bit at 5216
    doReset();
    waitTick(400, period);
    checkValue("def_first", period, 326);
    total = period;
    for (int i = 1; i < 16; i++) begin
      waitTick(400, period);
      total += period;
      checkValue($sformatf("def_bit%0d", i), BitTick, (i == 15) ? 1 : 0);
    end
    checkValue("def_bittime", total, 5216);

    // Resync at SampleIndex=7, Counter=5 with divisor 10
    doLoad(10, 0);
    for (int i = 0; i < 7; i++) waitTick(20, period);
    checkValue("rs_pre_index", SampleIndex, 7);
    repeat (5) @(negedge Clock);
    Resync = 1'b1;
    @(negedge Clock);
    Resync = 1'b0;
    checkValue("rs_tick_zero", SampleTick, 0);
    checkValue("rs_index_zero", SampleIndex, 0);
    waitTick(20, period);
    checkValue("rs_first", period, 10);
    checkValue("rs_first_index", SampleIndex, 1);
    total = period;
    for (int j = 1; j < 8; j++) begin
      checkValue($sformatf("rs_nomid%0d", j), MidBitTick, 0);
      waitTick(20, period);
      total += period;
    end
    checkValue("rs_mid", MidBitTick, 1);
    checkValue("rs_mid_time", total, 80);

    // Clamp of a too-small divisor, then cleared by a legal load
    doLoad(1, 0);
    checkValue("clamp_set", DivisorClamped, 1);
    waitTick(20, period);
    checkValue("clamp_period_a", period, 2);
    waitTick(20, period);
    checkValue("clamp_period_b", period, 2);
    doLoad(3, 0);
    checkValue("clamp_clear", DivisorClamped, 0);
    waitTick(20, period);
    checkValue("d3_period", period, 3);

    // Load and Resync together: load wins
    @(negedge Clock);
    DivisorInteger = 16'd5;
    DivisorFraction = 4'd0;
    LoadDivisor = 1'b1;
    Resync = 1'b1;
    @(negedge Clock);
    LoadDivisor = 1'b0;
    Resync = 1'b0;
    waitTick(20, period);
    checkValue("load_resync_period", period, 5);

    // Enable gap mid-period with divisor 6
    doLoad(6, 0);
    waitTick(20, period);
    checkValue("en_first", period, 6);
    repeat (3) @(negedge Clock);
    Enable = 1'b0;
    anyTick = 0;
    repeat (20) begin
      @(negedge Clock);
      if (SampleTick || BitTick || MidBitTick) anyTick = 1;
    end
    checkValue("en_gap_ticks", anyTick, 0);
    checkValue("en_gap_index", SampleIndex, 1);
    Enable = 1'b1;
    waitTick(20, period);
    checkValue("en_resume", period, 3);
    checkValue("en_resume_index", SampleIndex, 2);

    // Reset just before a terminal edge discards the pending tick
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checkValue("mid_rst_tick", SampleTick, 0);
    checkValue("mid_rst_bit", BitTick, 0);
    checkValue("mid_rst_mid", MidBitTick, 0);
    checkValue("mid_rst_index", SampleIndex, 0);
    checkValue("mid_rst_clamp", DivisorClamped, 0);
    Reset = 1'b0;
    waitTick(400, period);
    checkValue("mid_rst_period", period, 326);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/frac_baud_generator.md
Name: frac_baud_generator

Overview:
Parametrised successor to the fixed four-rate baud generator used by the UART transmitter and receiver. It takes a runtime-loadable integer-plus-fraction divisor, so any baud rate can be set from any system clock. All outputs are single-cycle clock enables, never derived clocks: an oversampling tick, a bit tick, and a mid-bit tick. A resync input lets the receiver align the bit phase to a detected start-bit edge.

Parameters:
DIV_WIDTH, 16, width of the integer divisor part (system clocks per sample tick)
FRAC_BITS, 4, width of the fractional divisor part; the fraction is in units of 1/2^FRAC_BITS clock
OVERSAMPLE, 16, sample ticks per bit; power of two, at least 4
RESET_DIVISOR, 326, integer divisor loaded at reset; 50 MHz / (9600 × 16) ≈ 325.5
IDX_WIDTH, $clog2(OVERSAMPLE), derived; width of SampleIndex

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high
Enable  input  1  count enable; when low, all state holds and all ticks are low
DivisorInteger  input  DIV_WIDTH  integer part of the new divisor
DivisorFraction  input  FRAC_BITS  fractional part of the new divisor
LoadDivisor  input  1  one-cycle strobe that captures the divisor inputs
Resync  input  1  one-cycle strobe that restarts the bit phase
SampleTick  output  1  one-cycle oversampling enable
BitTick  output  1  one-cycle enable once per bit period
MidBitTick  output  1  one-cycle enable at the middle of each bit
SampleIndex  output  IDX_WIDTH  sample-tick count within the current bit
DivisorClamped  output  1  sticky flag: the last load was clamped

Behaviour:
- Internal state:
  - ActInt, ActFrac: active divisor.
  - Counter (DIV_WIDTH+1 bits).
  - Acc (FRAC_BITS bits): fractional accumulator.
  - Extend (1 bit): lengthens the current period by one clock.
  - SampleIndex.
- Reset values: ActInt=RESET_DIVISOR, ActFrac=0, Counter=0, Acc=0, Extend=0, SampleIndex=0. All tick outputs are 0 and DivisorClamped=0.
- Priority per edge is Reset > LoadDivisor > Resync > Enable counting.
- Counting (Enable=1, no strobe):
  - Terminal condition is Counter == ActInt-1+Extend.
  - At terminal: Counter<=0 and SampleTick<=1.
  - At terminal, {carry, Acc} <= Acc+ActFrac, and Extend<=carry.
  - At terminal, SampleIndex<=SampleIndex+1, wrapping modulo OVERSAMPLE.
  - Otherwise Counter<=Counter+1 and SampleTick<=0.
- Period of each sample tick is ActInt+Extend clocks. The long-run average is ActInt+ActFrac/2^FRAC_BITS.
- All ticks are registered. Each pulses high for exactly one cycle following the terminal edge.
- BitTick is asserted with the SampleTick on which SampleIndex wraps from OVERSAMPLE-1 to 0.
- MidBitTick is asserted with the SampleTick on which SampleIndex goes from OVERSAMPLE/2-1 to OVERSAMPLE/2.
- Enable=0:
  - Counter, Acc, Extend and SampleIndex hold.
  - Ticks are 0 on the next cycle.
  - Counting resumes from the held values.
- LoadDivisor:
  - ActInt<=max(DivisorInteger,2) and ActFrac<=DivisorFraction.
  - Counter, Acc, Extend and SampleIndex are cleared; ticks are 0 on the next cycle.
  - DivisorClamped<=(DivisorInteger<2). The flag holds until the next load or reset.
  - The load takes effect regardless of Enable.
- Resync:
  - Counter, Acc, Extend and SampleIndex are cleared; ticks are 0 on the next cycle. Divisor is unchanged.
  - The first SampleTick follows a full period.
  - MidBitTick follows OVERSAMPLE/2 sample periods after the strobe; BitTick follows OVERSAMPLE periods.
  - Resync takes effect regardless of Enable.
- A Resync issued in the same cycle as LoadDivisor is absorbed by the load.
- Reset mid-period discards the partial count; the next period starts fresh from RESET_DIVISOR.
- Counter never exceeds ActInt. No wrap or overflow is possible because Counter is one bit wider than ActInt.

Test Plan:
- Reset, then load Int=4, Frac=0, Enable=1 -> SampleTick every 4 clocks; BitTick every 64 clocks; MidBitTick 32 clocks after each BitTick; SampleIndex cycles 0..15.
- Load Int=4, Frac=8 -> sample periods run 4,4,5,4,5,…; exactly 144 clocks for 32 SampleTicks; Acc=0 after every even tick.
- Reset only (defaults 326/0) -> first SampleTick 326 clocks after Reset falls; first BitTick after 5216 clocks.
- Int=10, Frac=0: pulse Resync when SampleIndex=7 and Counter=5 -> no tick that cycle; next SampleTick 10 clocks later with SampleIndex=1; MidBitTick 80 clocks after the strobe.
- Load Int=1 -> DivisorClamped=1 and period=2; then load Int=3 -> DivisorClamped=0 and period=3.
- Int=6: drop Enable for 20 cycles mid-period -> no ticks during the gap; the remaining count completes after re-enable. Assert Reset mid-period -> all outputs 0 on the next cycle.
